// File: rtl/track_pkg.sv
// rtl/track_pkg.sv - road-pattern constants, filter defaults and state encoding
package track_pkg;

    // Road patterns as {left, mid, right}; 1 = line seen under that sensor
    localparam logic [2:0] ERROR_ROAD   = 3'b000;
    localparam logic [2:0] TURN_ROAD001 = 3'b001;
    localparam logic [2:0] TURN_ROAD010 = 3'b010;
    localparam logic [2:0] TURN_ROAD011 = 3'b011;
    localparam logic [2:0] TURN_ROAD100 = 3'b100;
    localparam logic [2:0] TURN_ROAD101 = 3'b101;
    localparam logic [2:0] TURN_ROAD110 = 3'b110;
    localparam logic [2:0] TURN_ROAD111 = 3'b111;

    // 1 ms of stability and 0.5 s of line absence at 100 MHz
    localparam int DEF_STABLE_CYCLES = 100000;
    localparam int DEF_LOST_CYCLES   = 50000000;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } filt_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for one asynchronous bit
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // First flop may go metastable; second flop gives it a full cycle to settle
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/track_filter.sv
// rtl/track_filter.sv - debounce and classify the three IR line-tracker inputs
module track_filter
    import track_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int LOST_CYCLES   = DEF_LOST_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       left_track,
    input  logic       mid_track,
    input  logic       right_track,
    output logic [2:0] detect_road,
    output logic       road_valid,
    output logic       junction,
    output logic       lost,
    output logic       ready
);

    localparam logic [19:0] STABLE_MAX = 20'(STABLE_CYCLES - 1);
    localparam logic [26:0] LOST_MAX   = 27'(LOST_CYCLES);

    logic [2:0]  sync_road;
    logic [2:0]  candidate;
    logic [19:0] stable_cnt;
    logic [26:0] lost_cnt;
    filt_state_t state;

    logic cand_match;
    logic accept;
    logic update;

    sync_2ff u_sync_left  (.clk(clk), .rst(rst), .d(left_track),  .q(sync_road[2]));
    sync_2ff u_sync_mid   (.clk(clk), .rst(rst), .d(mid_track),   .q(sync_road[1]));
    sync_2ff u_sync_right (.clk(clk), .rst(rst), .d(right_track), .q(sync_road[0]));

    // Acceptance also requires the current sample to still match, so a pattern
    // must be seen on STABLE_CYCLES+1 consecutive synchronized samples
    assign cand_match = (sync_road == candidate);
    assign accept     = cand_match && (stable_cnt == STABLE_MAX);
    assign update     = accept && ((state == ST_INIT) || (candidate != detect_road));

    // Track the most recent synchronized pattern and how long it has held
    always_ff @(posedge clk) begin
        if (rst) begin
            candidate  <= ERROR_ROAD;
            stable_cnt <= '0;
        end else if (!cand_match) begin
            candidate  <= sync_road;
            stable_cnt <= '0;
        end else if (stable_cnt != STABLE_MAX) begin
            stable_cnt <= stable_cnt + 20'd1;
        end
    end

    // Control FSM with registered pattern, pulses and line-lost supervision
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_INIT;
            detect_road <= ERROR_ROAD;
            road_valid  <= 1'b0;
            junction    <= 1'b0;
            lost        <= 1'b0;
            ready       <= 1'b0;
            lost_cnt    <= '0;
        end else begin
            road_valid <= update;
            junction   <= update && (candidate == TURN_ROAD111)
                                 && (detect_road != TURN_ROAD111);
            if (update) begin
                detect_road <= candidate;
            end
            case (state)
                ST_INIT: begin
                    if (update) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (update && (candidate != ERROR_ROAD)) begin
                        lost_cnt <= '0;
                        lost     <= 1'b0;
                    end else if ((detect_road == ERROR_ROAD) && (lost_cnt != LOST_MAX)) begin
                        lost_cnt <= lost_cnt + 27'd1;
                        if ((lost_cnt + 27'd1) == LOST_MAX) begin
                            lost <= 1'b1;
                        end
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_track_filter.sv
// tb/tb_track_filter.sv - scoreboard bench for track_filter
module tb_track_filter;

    localparam int SC = 4;
    localparam int LC = 10;

    typedef struct {
        int         at;
        logic [2:0] road;
        logic       junc;
    } upd_t;

    typedef struct {
        int   at;
        logic val;
    } lost_t;

    typedef struct {
        int         at;
        logic [2:0] road;
        logic       valid;
        logic       junc;
        logic       lost;
        logic       ready;
    } snap_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       left_track = 1'b0;
    logic       mid_track = 1'b0;
    logic       right_track = 1'b0;
    logic [2:0] detect_road;
    logic       road_valid;
    logic       junction;
    logic       lost;
    logic       ready;

    int    cyc = 0;
    int    tests = 0;
    int    fails = 0;
    logic  done = 1'b0;
    logic  prev_lost = 1'b0;
    upd_t  upd_q[$];
    lost_t lost_q[$];
    snap_t snap_q[$];

    track_filter #(.STABLE_CYCLES(SC), .LOST_CYCLES(LC)) dut (
        .clk(clk),
        .rst(rst),
        .left_track(left_track),
        .mid_track(mid_track),
        .right_track(right_track),
        .detect_road(detect_road),
        .road_valid(road_valid),
        .junction(junction),
        .lost(lost),
        .ready(ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic pins(input logic [2:0] p);
        {left_track, mid_track, right_track} = p;
    endtask

    task automatic exp_upd(input int at, input logic [2:0] road, input logic junc);
        upd_t u;
        u.at = at; u.road = road; u.junc = junc;
        upd_q.push_back(u);
    endtask

    task automatic exp_lost(input int at, input logic val);
        lost_t l;
        l.at = at; l.val = val;
        lost_q.push_back(l);
    endtask

    task automatic exp_zero(input int at);
        snap_t s;
        s.at = at; s.road = 3'b000; s.valid = 1'b0; s.junc = 1'b0; s.lost = 1'b0; s.ready = 1'b0;
        snap_q.push_back(s);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: the only place comparisons are made and counted
    always @(negedge clk) begin
        upd_t  u;
        lost_t l;
        snap_t s;
        while (snap_q.size() > 0 && snap_q[0].at == cyc) begin
            s = snap_q.pop_front();
            tests++;
            if (detect_road !== s.road || road_valid !== s.valid || junction !== s.junc ||
                lost !== s.lost || ready !== s.ready) begin
                fails++;
                $display("FAIL snapshot edge %0d: got road=%b valid=%b junc=%b lost=%b ready=%b, required road=%b valid=%b junc=%b lost=%b ready=%b",
                         cyc, detect_road, road_valid, junction, lost, ready,
                         s.road, s.valid, s.junc, s.lost, s.ready);
            end
        end
        if (road_valid === 1'b1) begin
            tests++;
            if (upd_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_update edge %0d: got road=%b junc=%b, required no pulse",
                         cyc, detect_road, junction);
            end else begin
                u = upd_q.pop_front();
                if (cyc != u.at || detect_road !== u.road || junction !== u.junc || ready !== 1'b1) begin
                    fails++;
                    $display("FAIL update: got edge %0d road=%b junc=%b ready=%b, required edge %0d road=%b junc=%b ready=1",
                             cyc, detect_road, junction, ready, u.at, u.road, u.junc);
                end
            end
        end else if (junction !== 1'b0) begin
            tests++;
            fails++;
            $display("FAIL junction_alone edge %0d: got junc=%b valid=%b, required junc=0", cyc, junction, road_valid);
        end
        if (lost !== prev_lost) begin
            tests++;
            if (lost_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_lost edge %0d: got lost=%b, required no change", cyc, lost);
            end else begin
                l = lost_q.pop_front();
                if (cyc != l.at || lost !== l.val) begin
                    fails++;
                    $display("FAIL lost: got edge %0d lost=%b, required edge %0d lost=%b", cyc, lost, l.at, l.val);
                end
            end
        end
        prev_lost = lost;
        if (done) begin
            foreach (upd_q[i]) begin
                tests++; fails++;
                $display("FAIL missing_update: got none, required edge %0d road=%b", upd_q[i].at, upd_q[i].road);
            end
            foreach (lost_q[i]) begin
                tests++; fails++;
                $display("FAIL missing_lost: got none, required edge %0d lost=%b", lost_q[i].at, lost_q[i].val);
            end
            foreach (snap_q[i]) begin
                tests++; fails++;
                $display("FAIL missing_snapshot: got none, required edge %0d", snap_q[i].at);
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    // Directed stimulus; every pin change lands on a negedge so edge base+1 samples it
    initial begin
        int base;
        pins(3'b010);
        rst = 1'b1;
        @(negedge clk);
        exp_zero(cyc + 1);
        exp_zero(cyc + 2);
        wait_n(3);

        // First acceptance after reset: 010 at edge 7, ready still low before it
        rst = 1'b0;
        pins(3'b010);
        base = cyc;
        exp_zero(base + 3);
        exp_upd(base + 7, 3'b010, 1'b0);
        wait_n(12);

        // Glitches of 3 and 4 cycles never reach the output
        pins(3'b111); wait_n(3); pins(3'b010); wait_n(12);
        pins(3'b111); wait_n(4); pins(3'b010); wait_n(12);

        // A 5-cycle pattern is just long enough to be accepted
        pins(3'b111);
        base = cyc;
        exp_upd(base + 7, 3'b111, 1'b1);
        wait_n(5);
        pins(3'b010);
        exp_upd(cyc + 7, 3'b010, 1'b0);
        wait_n(12);

        // Steady junction: one pulse, then 50 quiet cycles
        pins(3'b111);
        base = cyc;
        exp_upd(base + 7, 3'b111, 1'b1);
        wait_n(57);
        pins(3'b010);
        exp_upd(cyc + 7, 3'b010, 1'b0);
        wait_n(12);

        // Line absent: 000 at edge 7, lost at edge 17, cleared together with the next update
        pins(3'b000);
        base = cyc;
        exp_upd(base + 7, 3'b000, 1'b0);
        exp_lost(base + 17, 1'b1);
        wait_n(25);
        pins(3'b010);
        base = cyc;
        exp_upd(base + 7, 3'b010, 1'b0);
        exp_lost(base + 7, 1'b0);
        wait_n(12);

        // Reset in the middle of a 010->110 transition discards the partial count
        pins(3'b110);
        base = cyc;
        wait_n(4);
        rst = 1'b1;
        exp_zero(base + 5);
        exp_zero(base + 6);
        wait_n(1);
        rst = 1'b0;
        base = cyc;
        exp_upd(base + 7, 3'b110, 1'b0);
        wait_n(12);

        done = 1'b1;
        wait_n(3);
        $display("FAIL watchdog: got no summary, required summary");
        $fatal(1);
    end

endmodule
